sdram_rd_capture: RTL and testbench

- Sits directly downstream of the SDRAM read command generator.
- Watches the 4-bit read command bus and, after CAS latency, samples the 4-beat read burst from the SDRAM data bus.
- Buffers the beats in a small FIFO and presents them to the consumer with a valid/ready handshake.
- Exports a space flag so the read path or arbiter issues a new burst only when buffer room is guaranteed.

---
 rtl/sdram_pkg.sv | 14 +
 rtl/sdram_sync_fifo.sv | 49 ++++
 rtl/sdram_rd_capture.sv | 101 ++++++++++
 tb/tb_sdram_rd_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and read-burst constants.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WE   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   localparam int BURST_LEN  = 4;
   localparam int CL_DEFAULT = 3;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Synchronous FIFO with wrap-flag pointers; head word is combinational and reads 0 while empty.
module sdram_sync_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_push;
   logic         w_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_level = r_wptr - r_rptr;
   assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   // NOTE: storage has no reset; o_data is masked while empty so stale entries never show.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/sdram_rd_capture.sv
// Captures 4-beat SDRAM read bursts CL cycles after each read command and queues them for a consumer.
module sdram_rd_capture
   import sdram_pkg::*;
#(
   parameter int CL    = CL_DEFAULT,
   parameter int DEPTH = 16,
   parameter int DW    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             rd_cmd,
   input  logic [DW-1:0]          sdram_dq,
   output logic [DW-1:0]          dout_data,
   output logic                   dout_last,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   rd_space,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   logic [CL-1:0] r_issue;
   logic          r_active;
   logic [1:0]    r_beat;
   logic          r_overflow;
   logic          r_rd_space;

   logic          w_start;
   logic          w_capture;
   logic [1:0]    w_beat;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [DW-1:0] w_head_data;
   logic          w_head_last;
   logic [3:0]    w_pending;

   // The oldest issue bit marks the edge where beat 0 lands; a newer start restarts the counter.
   assign w_start   = r_issue[CL-1];
   assign w_capture = w_start || r_active;
   assign w_beat    = w_start ? 2'd0 : r_beat;
   assign w_pop     = dout_valid && dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue    <= '0;
         r_active   <= 1'b0;
         r_beat     <= 2'd0;
         r_overflow <= 1'b0;
         r_rd_space <= 1'b1;
      end else begin
         r_issue <= {r_issue[CL-2:0], (rd_cmd == CMD_RD)};
         if (w_start) begin
            r_active <= 1'b1;
            r_beat   <= 2'd1;
         end else if (r_active) begin
            if (r_beat == 2'd3) r_active <= 1'b0;
            r_beat <= r_beat + 2'd1;
         end
         if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
         r_rd_space <= (int'(level) + int'(w_pending) + BURST_LEN) <= DEPTH;
      end
   end

   // Pending = future capture edges covered by the active burst or any scheduled burst.
   // NOTE: v_cov is a per-iteration temporary, so it is assigned first in every pass to avoid a latch.
   always_comb begin
      logic v_cov;
      w_pending = '0;
      v_cov     = 1'b0;
      for (int d = 1; d <= CL + 3; d++) begin
         v_cov = r_active && (d <= 4 - int'(r_beat));
         for (int j = 0; j < CL; j++) begin
            if (r_issue[j] && (d >= CL - j) && (d <= CL - j + 3)) v_cov = 1'b1;
         end
         if (v_cov) w_pending = w_pending + 4'd1;
      end
   end

   sdram_sync_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_capture),
      .i_data  ({(w_beat == 2'd3), sdram_dq}),
      .i_pop   (w_pop),
      .o_data  ({w_head_last, w_head_data}),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   assign dout_valid = !w_empty;
   assign dout_data  = w_head_data;
   assign dout_last  = w_head_last;
   assign rd_space   = r_rd_space;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Drives CL=3 and CL=2 instances from one stimulus stream and checks both against a burst-plan model.
module tb_sdram_rd_capture;
   import sdram_pkg::*;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    rd_cmd;
   logic [DW-1:0] sdram_dq;
   logic          dout_ready;

   logic [DW-1:0] d3_data, d2_data;
   logic          d3_last, d2_last, d3_valid, d2_valid;
   logic          d3_space, d2_space, d3_ovf, d2_ovf;
   logic [LW-1:0] d3_level, d2_level;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: plan[m][edge%64] = beat index expected at that edge (-1 = none); FIFO as shift array.
   int            plan  [2][64];
   logic [DW:0]   mf    [2][DEPTH];
   int            mcnt  [2];
   logic          mov   [2];
   logic          mspace[2];
   int            edge_n = 0;

   always #5 clk = ~clk;

   sdram_rd_capture #(.CL(3), .DEPTH(DEPTH), .DW(DW)) u_dut3 (
      .clk(clk), .rst(rst), .rd_cmd(rd_cmd), .sdram_dq(sdram_dq),
      .dout_data(d3_data), .dout_last(d3_last), .dout_valid(d3_valid), .dout_ready(dout_ready),
      .rd_space(d3_space), .level(d3_level), .overflow(d3_ovf));

   sdram_rd_capture #(.CL(2), .DEPTH(DEPTH), .DW(DW)) u_dut2 (
      .clk(clk), .rst(rst), .rd_cmd(rd_cmd), .sdram_dq(sdram_dq),
      .dout_data(d2_data), .dout_last(d2_last), .dout_valid(d2_valid), .dout_ready(dout_ready),
      .rd_space(d2_space), .level(d2_level), .overflow(d2_ovf));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int cl;
         int pend;
         int k;
         int slot;
         cl = (m == 0) ? 3 : 2;
         if (rst) begin
            mcnt[m] = 0; mov[m] = 1'b0; mspace[m] = 1'b1;
            for (int s = 0; s < 64; s++) plan[m][s] = -1;
         end else begin
            pend = 0;
            for (int s = 0; s < 64; s++) if (plan[m][s] >= 0) pend++;
            mspace[m] = (mcnt[m] + pend + BURST_LEN <= DEPTH);
            slot = edge_n % 64;
            k = plan[m][slot];
            plan[m][slot] = -1;
            if (dout_ready && mcnt[m] > 0) begin
               for (int i = 0; i < mcnt[m] - 1; i++) mf[m][i] = mf[m][i+1];
               mcnt[m]--;
            end
            if (k >= 0) begin
               if (mcnt[m] < DEPTH) begin
                  mf[m][mcnt[m]] = {(k == 3), sdram_dq};
                  mcnt[m]++;
               end else mov[m] = 1'b1;
            end
            if (rd_cmd == CMD_RD)
               for (int b = 0; b < BURST_LEN; b++) plan[m][(edge_n + cl + b) % 64] = b;
         end
      end
      edge_n++;
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         logic [DW-1:0] e_data;
         logic          e_last;
         string         p;
         p      = (m == 0) ? "cl3" : "cl2";
         e_data = (mcnt[m] > 0) ? mf[m][0][DW-1:0] : '0;
         e_last = (mcnt[m] > 0) ? mf[m][0][DW] : 1'b0;
         check({p, "_valid"}, 32'((m == 0) ? d3_valid : d2_valid), 32'(mcnt[m] > 0));
         check({p, "_data"},  32'((m == 0) ? d3_data  : d2_data),  32'(e_data));
         check({p, "_last"},  32'((m == 0) ? d3_last  : d2_last),  32'(e_last));
         check({p, "_level"}, 32'((m == 0) ? d3_level : d2_level), 32'(mcnt[m]));
         check({p, "_space"}, 32'((m == 0) ? d3_space : d2_space), 32'(mspace[m]));
         check({p, "_ovf"},   32'((m == 0) ? d3_ovf   : d2_ovf),   32'(mov[m]));
      end
   endtask

   task automatic step(input logic [3:0] cmd, input logic [DW-1:0] dq, input logic rdy, input logic r);
      rd_cmd = cmd; sdram_dq = dq; dout_ready = rdy; rst = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) step(CMD_NOP, '0, rdy, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] dq4 [4];
      logic [3:0]    others [5];
      dq4    = '{16'd3, 16'd5, 16'd7, 16'd9};
      others = '{CMD_NOP, CMD_PRE, CMD_AREF, CMD_ACT, CMD_WE};
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0; mov[m] = 1'b0; mspace[m] = 1'b1;
         for (int s = 0; s < 64; s++) plan[m][s] = -1;
      end

      step(CMD_NOP, '0, 1'b0, 1'b1);
      step(CMD_NOP, '0, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Single burst, dq timed for CL=3.
      step(CMD_RD, '0, 1'b1, 1'b0);
      idle(2, 1'b1);
      for (int i = 0; i < 4; i++) step(CMD_NOP, dq4[i], 1'b1, 1'b0);
      idle(4, 1'b1);

      // Back-to-back bursts, then an interrupted burst.
      for (int i = 0; i < 12; i++)
         step((i == 0 || i == 4) ? CMD_RD : CMD_NOP, (i >= 3 && i <= 10) ? 16'(i - 2) : 16'h0, 1'b1, 1'b0);
      idle(3, 1'b1);
      for (int i = 0; i < 10; i++)
         step((i == 0 || i == 2) ? CMD_RD : CMD_NOP, (i >= 3 && i <= 8) ? 16'(16'h11 + i - 3) : 16'h0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // Fill to 16 with no consumer, then push and pop together on the CL=3 capture edges.
      for (int i = 0; i < 16; i++)
         step((i % 4 == 0) ? CMD_RD : CMD_NOP, 16'(16'h100 + i), 1'b0, 1'b0);
      idle(4, 1'b0);
      check("full_level", 32'(d3_level), 32'(DEPTH));
      for (int i = 0; i < 8; i++)
         step((i == 0) ? CMD_RD : CMD_NOP, 16'(16'h200 + i), (i >= 3 && i <= 6), 1'b0);
      check("pushpop_level", 32'(d3_level), 32'(DEPTH));
      check("pushpop_ovf", 32'(d3_ovf), 32'(0));

      // Forced burst while full: dropped, overflow sticks; then drain.
      step(CMD_RD, '0, 1'b0, 1'b0);
      idle(8, 1'b0);
      check("drop_ovf", 32'(d3_ovf), 32'(1));
      check("drop_level", 32'(d3_level), 32'(DEPTH));
      idle(20, 1'b1);
      check("drain_level", 32'(d3_level), 32'(0));
      check("drain_space", 32'(d3_space), 32'(1));
      check("drain_ovf", 32'(d3_ovf), 32'(1));

      // Reset at E0+CL+1 mid-burst, then single burst with dq timed for CL=2.
      step(CMD_RD, '0, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) step(CMD_NOP, 16'(16'h300 + i), 1'b1, 1'b0);
      step(CMD_NOP, 16'h3ff, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(CMD_NOP, 16'h3ee, 1'b1, 1'b0);
      step(CMD_RD, '0, 1'b1, 1'b0);
      idle(1, 1'b1);
      for (int i = 0; i < 4; i++) step(CMD_NOP, dq4[i], 1'b1, 1'b0);
      idle(5, 1'b1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) == 0) ? CMD_RD : others[$urandom_range(0, 4)],
              16'($urandom), 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
      idle(12, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
